// File: rtl/rename_pkg.sv
// Shared types for the rename/dispatch queue: uop layout,
// reservation-station target and CSR serialisation states.
package rename_pkg;

  localparam int ROB_W  = 7;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [31:2]       addr;
    logic [4:0]        rsop;
    logic [ROB_W-1:0]  robid;
    logic [5:0]        rd;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              uses_imm;
    logic              uses_memory;
    logic              uses_pc;
    logic              csr_access;
    logic              forward;
    logic              inhibit;
    logic [31:2]       target;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [DATA_W-1:0] imm;
  } uop_t;

  localparam int UOP_W = $bits(uop_t);

  typedef enum logic [1:0] {
    RS_EXERS,
    RS_LSQ,
    RS_CSR
  } rs_tgt_e;

  typedef enum logic [1:0] {
    CSR_IDLE,
    CSR_DRAIN,
    CSR_ISSUE,
    CSR_WAIT
  } csr_st_e;

endpackage

// File: rtl/uop_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two
// so the pointers wrap by plain overflow.
module uop_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_clr;

  assign w_clr  = rst | i_flush;
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_clr) r_mem[r_wp] <= i_data;
  end

  assign o_data  = r_mem[r_rp];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/rename_dispatch_q.sv
// In-order uop queue between decode and the back end: operand
// selection, tag allocation and CSR serialisation at dispatch.
module rename_dispatch_q
  import rename_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ROBID_W = 7,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rob_flush,
  input  logic               decode_rename_valid,
  input  logic [UOP_W-1:0]   decode_uop,
  output logic               rename_stall,
  output logic [4:0]         rename_rs1,
  output logic [4:0]         rename_rs2,
  input  logic               rat_rs1_valid,
  input  logic               rat_rs2_valid,
  input  logic [XLEN-1:0]    rat_rs1_tagval,
  input  logic [XLEN-1:0]    rat_rs2_tagval,
  output logic               rename_alloc,
  output logic [5:0]         rename_rd,
  output logic [ROBID_W-1:0] rename_robid,
  output logic               rename_exers_write,
  output logic               rename_lsq_write,
  output logic               rename_csr_write,
  output logic [4:0]         rename_op,
  output logic               rename_op1ready,
  output logic               rename_op2ready,
  output logic [XLEN-1:0]    rename_op1,
  output logic [XLEN-1:0]    rename_op2,
  output logic [XLEN-1:0]    rename_imm,
  input  logic               exers_stall,
  input  logic               lsq_stall,
  input  logic               csr_stall,
  input  logic               rob_empty,
  input  logic               csr_done,
  output logic               rename_wb_valid,
  output logic [29:0]        rename_wb_result,
  output logic               rename_inhibit
);

  logic [UOP_W-1:0] w_head_raw;
  uop_t             w_head;
  logic             w_empty;
  logic             w_full;
  logic             w_head_valid;
  rs_tgt_e          w_tgt;
  logic             w_tgt_stall;
  logic             w_hold;
  logic             w_dispatch;
  logic             w_unused;
  csr_st_e          r_state;

  uop_fifo #(
    .DEPTH (DEPTH),
    .W     (UOP_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (rob_flush),
    .i_push  (decode_rename_valid),
    .i_data  (decode_uop),
    .i_pop   (w_dispatch),
    .o_data  (w_head_raw),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_head       = uop_t'(w_head_raw);
  assign w_head_valid = ~w_empty;
  assign rename_stall = w_full;
  assign w_unused     = w_head.uses_imm;

  always_comb begin
    w_tgt = RS_EXERS;
    if (w_head.uses_memory)     w_tgt = RS_LSQ;
    else if (w_head.csr_access) w_tgt = RS_CSR;
  end

  always_comb begin
    unique case (w_tgt)
      RS_LSQ:  w_tgt_stall = lsq_stall;
      RS_CSR:  w_tgt_stall = csr_stall;
      default: w_tgt_stall = exers_stall;
    endcase
  end

  // A CSR at the head in IDLE only starts the drain; it issues from ISSUE.
  assign w_hold = ((r_state == CSR_IDLE) & w_head.csr_access)
                | (r_state == CSR_DRAIN)
                | (r_state == CSR_WAIT);

  assign w_dispatch = w_head_valid & ~w_tgt_stall & ~w_hold;

  always_ff @(posedge clk) begin
    if (rst || rob_flush) begin
      r_state <= CSR_IDLE;
    end else begin
      unique case (r_state)
        CSR_IDLE:
          if (w_head_valid && w_head.csr_access) r_state <= CSR_DRAIN;
        CSR_DRAIN:
          if (rob_empty) r_state <= CSR_ISSUE;
        CSR_ISSUE:
          if (w_dispatch) r_state <= CSR_WAIT;
        CSR_WAIT:
          if (csr_done) r_state <= CSR_IDLE;
        default:
          r_state <= CSR_IDLE;
      endcase
    end
  end

  assign rename_exers_write = w_dispatch & (w_tgt == RS_EXERS);
  assign rename_lsq_write   = w_dispatch & (w_tgt == RS_LSQ);
  assign rename_csr_write   = w_dispatch & (w_tgt == RS_CSR);

  assign rename_rs1       = w_head.rs1;
  assign rename_rs2       = w_head.rs2;
  assign rename_robid     = ROBID_W'(w_head.robid);
  assign rename_op        = w_head.rsop;
  assign rename_imm       = XLEN'(w_head.imm);
  assign rename_rd        = w_head.rd | {w_head.forward, 5'b0};
  assign rename_alloc     = w_dispatch & ~rename_rd[5];
  assign rename_wb_valid  = w_dispatch & w_head.forward;
  assign rename_wb_result = w_head.target;
  assign rename_inhibit   = w_dispatch & w_head.inhibit;

  always_comb begin
    rename_op1      = XLEN'(w_head.imm);
    rename_op2      = '0;
    rename_op1ready = 1'b1;
    rename_op2ready = 1'b1;
    case ({w_head.uses_rs1, w_head.uses_pc})
      2'b00: begin
        rename_op1 = w_head.csr_access ? XLEN'(w_head.rs1)
                                       : XLEN'(w_head.imm);
      end
      2'b01: begin
        rename_op1 = XLEN'({w_head.addr, 2'b00});
        rename_op2 = XLEN'(w_head.imm);
      end
      2'b10: begin
        rename_op1      = rat_rs1_tagval;
        rename_op1ready = rat_rs1_valid;
        if (w_head.uses_rs2) begin
          rename_op2      = rat_rs2_tagval;
          rename_op2ready = rat_rs2_valid;
        end else begin
          rename_op2 = XLEN'(w_head.imm);
        end
      end
      default: ;
    endcase
  end

endmodule
